// File: rtl/seq_tx_pkg.sv
// Shared types and default constants for the serial pattern transmitter.
package seq_tx_pkg;

    // Transmitter phase; PAR is only entered when the parity frame bit is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } tx_state_t;

    localparam int         SEQ_TX_DATA_W   = 8;
    localparam int         SEQ_TX_PRE_W    = 2;
    localparam logic [1:0] SEQ_TX_PREAMBLE = 2'b01;

    // Larger of two widths, used to size the shared bit counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: parallel load, left shift, MSB tap.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_b,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] shreg;

    // Load has priority so a new word can be captured on the edge a frame ends.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= shreg << 1;
        end
    end

    assign msb = shreg[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: preamble then payload MSB first, one bit per clock.
// Optional even-parity trailer bit is built in when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               DATA_W   = SEQ_TX_DATA_W,
    parameter int               PRE_W    = SEQ_TX_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(SEQ_TX_PREAMBLE)
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_active,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(max_int(PRE_W, DATA_W) + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [PRE_W-1:0] PRE_MSB   = PRE_W'(1) << (PRE_W - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             bit_next;
    logic             active_next;
    logic             done_next;
    logic             last_bit;
    logic             accept;
    logic             load;
    logic             shift;
    logic             data_msb;

    piso_shift_reg #(
        .W (DATA_W)
    ) u_payload (
        .clock   (clock),
        .reset_b (reset_b),
        .load    (load),
        .shift   (shift),
        .din     (in_data),
        .msb     (data_msb)
    );

`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic parity;

    // Even parity of the accepted word, captured alongside the payload.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^in_data;
        end
    end

    assign last_bit = (state == PAR);
`else
    assign last_bit = (state == DATA) && (cnt == DATA_LAST);
`endif

    assign in_ready = (state == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;

    // Next phase, counter and line bit; the registered line always carries the bit of the current phase/count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        done_next  = last_bit;
        if (accept) begin
            state_next = PRE;
            cnt_next   = '0;
            bit_next   = PREAMBLE[PRE_W-1];
            load       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        bit_next   = data_msb;
                        shift      = 1'b1;
                    end else begin
                        cnt_next   = cnt + CNT_W'(1);
                        // Select the preamble bit one position below the one now on the line.
                        bit_next   = |(PREAMBLE & ((PRE_MSB >> cnt) >> 1));
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt_next   = '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        state_next = PAR;
                        bit_next   = parity;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        cnt_next   = cnt + CNT_W'(1);
                        bit_next   = data_msb;
                        shift      = 1'b1;
                    end
                end
                PAR: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
        active_next = (state_next != IDLE);
    end

    // State and registered line outputs; reset abandons any frame without a done pulse.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            cnt        <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ser_out    <= bit_next;
            ser_active <= active_next;
            frame_done <= done_next;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; honours SEQ_PATTERN_TX_PARITY_EN for expected frames.
module tb_seq_pattern_tx;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clock;
    logic       reset_b;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ser_out;
    logic       ser_active;
    logic       frame_done;

    int checks_total  = 0;
    int checks_passed = 0;

    seq_pattern_tx dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-14s got %0h", tag, got);
        end else begin
            $display("FAIL %-14s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Starts in the first frame cycle, ends in the last bit cycle.
    task automatic collect_frame(input bit scramble, output logic [15:0] bits,
                                 output logic all_act, output int done_cnt);
        bits     = '0;
        all_act  = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            bits    = {bits[14:0], ser_out};
            all_act = all_act & ser_active;
            if (i > 0 && frame_done) done_cnt++;
            if (i == 1) check("rdy_mid", {31'd0, in_ready}, 32'd0);
            if (i == FL - 1) check("rdy_last", {31'd0, in_ready}, 32'd1);
            if (i < FL - 1) begin
                if (scramble) in_data = 8'($urandom);
                step();
            end
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] data,
                              input logic [15:0] exp_bits, input bit scramble);
        logic [15:0] bits;
        logic        act;
        int          dcnt;
        in_valid = 1'b1;
        in_data  = data;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        collect_frame(scramble, bits, act, dcnt);
        check({tag, "_bits"}, {16'd0, bits}, {16'd0, exp_bits});
        check({tag, "_act"}, {31'd0, act}, 32'd1);
        check({tag, "_middone"}, dcnt, 0);
        step();
        check({tag, "_done"}, {29'd0, frame_done, ser_active, ser_out}, 32'b100);
        step();
        check({tag, "_after"}, {29'd0, frame_done, ser_active, ser_out}, 32'b000);
    endtask

    logic [15:0] exp_a5, exp_3c, exp_81, exp_07, exp_c3;
    logic [15:0] bits1, bits2;
    logic        act1, act2;
    int          dc1, dc2;

    initial begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
        exp_a5 = 16'b0000_0_01_10100101_0;
        exp_3c = 16'b0000_0_01_00111100_0;
        exp_81 = 16'b0000_0_01_10000001_0;
        exp_07 = 16'b0000_0_01_00000111_1;
        exp_c3 = 16'b0000_0_01_11000011_0;
`else
        exp_a5 = 16'b000000_01_10100101;
        exp_3c = 16'b000000_01_00111100;
        exp_81 = 16'b000000_01_10000001;
        exp_07 = 16'b000000_01_00000111;
        exp_c3 = 16'b000000_01_11000011;
`endif
        reset_b  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check("reset_state", {28'd0, ser_out, ser_active, frame_done, in_ready}, 32'b0001);
        #11;
        reset_b = 1'b1;

        // Idle with no valid.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle", {28'd0, ser_out, ser_active, frame_done, in_ready}, 32'b0001);
        end

        send_frame("single", 8'hA5, exp_a5, 1'b0);

        // Back-to-back: second word held valid through the first frame.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_data  = 8'h3C;
        collect_frame(1'b0, bits1, act1, dc1);
        step();
        in_valid = 1'b0;
        check("b2b_seam", {29'd0, frame_done, ser_active, ser_out}, 32'b110);
        collect_frame(1'b0, bits2, act2, dc2);
        check("b2b_bits1", {16'd0, bits1}, {16'd0, exp_a5});
        check("b2b_bits2", {16'd0, bits2}, {16'd0, exp_3c});
        check("b2b_act", {30'd0, act1, act2}, 32'b11);
        check("b2b_middone", dc1 + dc2, 0);
        step();
        check("b2b_done2", {29'd0, frame_done, ser_active, ser_out}, 32'b100);
        step();

        // Reset during data bit 3 of an all-ones word.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("pre_rst_line", {30'd0, ser_active, ser_out}, 32'b11);
        #2;
        reset_b = 1'b0;
        #1;
        check("rst_mid", {29'd0, frame_done, ser_active, ser_out}, 32'b000);
        step();
        reset_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst", {28'd0, frame_done, ser_active, ser_out, in_ready}, 32'b0001);
        end
        send_frame("clean", 8'hC3, exp_c3, 1'b0);

        // Payload must be immune to in_data changes after accept.
        send_frame("hold", 8'h81, exp_81, 1'b1);

        // Parity coverage (odd and even weight words).
        send_frame("par_a5", 8'hA5, exp_a5, 1'b0);
        send_frame("par_07", 8'h07, exp_07, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
